// File: rtl/intmul_arbiter_pkg.sv
// Shared multiplier configuration: parameter bundle, pipeline latency and
// DSP partial-product geometry used by intmul_standard and its arbiter.
package intmul_arbiter_pkg;

  localparam int DSP_B_W = 18;

  typedef struct packed {
    int ff_in;
    int ff_mul;
    int ff_out;
    int use_csa;
    int ff_csa;
  } intmul_params_t;

  function automatic int intmul_lat(input intmul_params_t p);
    return p.ff_in + p.ff_mul + p.ff_out +
           (((p.use_csa != 32'sd0) && (p.ff_csa != 32'sd0)) ? 32'sd1 : 32'sd0);
  endfunction

  function automatic int id_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/intmul_arbiter_if.sv
// Requester and response bundle of the shared multiplier arbiter.
interface intmul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W_A   = 32,
  parameter int W_B   = 32
);
  localparam int ID_W = intmul_arbiter_pkg::id_width(N_REQ);

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*W_A-1:0] req_a;
  logic [N_REQ*W_B-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [W_A+W_B-1:0]   rsp_c;
  logic                 busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_c, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_c, busy
  );
endinterface

// File: rtl/intmul_arbiter_fifo.sv
// Registered first-word-fall-through response FIFO; data storage is not reset.
module intmul_arbiter_fifo #(
  parameter int W     = 8,
  parameter int D     = 4,
  parameter int CNT_W = $clog2(D + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]     mem_r [D];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             push_ok_s, pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(D - 1)) ? '0 : p + PTR_W'(1'b1);
  endfunction

  assign empty     = (cnt_r == '0);
  assign full      = (cnt_r == CNT_W'(D));
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];
  assign count     = cnt_r;

  // Entry storage
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_ok_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1'b1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1'b1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end
endmodule

// File: rtl/intmul_standard.sv
// Unsigned multiplier with optional input, CSA, product and output register
// stages; the data path carries no reset.
module intmul_standard
  import intmul_arbiter_pkg::*;
#(
  parameter int W_A     = 32,
  parameter int W_B     = 32,
  parameter int FF_IN   = 1,
  parameter int FF_MUL  = 1,
  parameter int FF_OUT  = 1,
  parameter int USE_CSA = 0,
  parameter int FF_CSA  = 0
) (
  input  logic               clk,
  input  logic [W_A-1:0]     a,
  input  logic [W_B-1:0]     b,
  output logic [W_A+W_B-1:0] c
);
  localparam int W_C = W_A + W_B;

  logic [W_A-1:0] a_s;
  logic [W_B-1:0] b_s;
  logic [W_C-1:0] prod_s, mul_s;

  if (FF_IN != 0) begin : g_in_ff
    logic [W_A-1:0] a_r;
    logic [W_B-1:0] b_r;
    // Operand capture
    always_ff @(posedge clk) begin
      a_r <= a;
      b_r <= b;
    end
    assign a_s = a_r;
    assign b_s = b_r;
  end else begin : g_in_wire
    assign a_s = a;
    assign b_s = b;
  end

  // CSA mode splits B at the DSP port width; needs W_B > DSP_B_W.
  if (USE_CSA != 0) begin : g_csa
    logic [W_C-1:0] pp_lo_s, pp_hi_s;
    assign pp_lo_s = W_C'(a_s) * W_C'(b_s[DSP_B_W-1:0]);
    assign pp_hi_s = (W_C'(a_s) * W_C'(b_s[W_B-1:DSP_B_W])) << DSP_B_W;
    if (FF_CSA != 0) begin : g_csa_ff
      logic [W_C-1:0] pp_lo_r, pp_hi_r;
      // Partial-product register ahead of the final add
      always_ff @(posedge clk) begin
        pp_lo_r <= pp_lo_s;
        pp_hi_r <= pp_hi_s;
      end
      assign prod_s = pp_lo_r + pp_hi_r;
    end else begin : g_csa_comb
      assign prod_s = pp_lo_s + pp_hi_s;
    end
  end else begin : g_mul
    assign prod_s = W_C'(a_s) * W_C'(b_s);
  end

  if (FF_MUL != 0) begin : g_mul_ff
    logic [W_C-1:0] mul_r;
    // Product register
    always_ff @(posedge clk) mul_r <= prod_s;
    assign mul_s = mul_r;
  end else begin : g_mul_wire
    assign mul_s = prod_s;
  end

  if (FF_OUT != 0) begin : g_out_ff
    logic [W_C-1:0] out_r;
    // Output register
    always_ff @(posedge clk) out_r <= mul_s;
    assign c = out_r;
  end else begin : g_out_wire
    assign c = mul_s;
  end
endmodule

// File: rtl/intmul_arbiter.sv
// Round-robin sharing of one pipelined multiplier among N_REQ requesters,
// with a tag pipe for requester IDs and a credit-guarded response FIFO.
module intmul_arbiter
  import intmul_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W_A     = 32,
  parameter int W_B     = 32,
  parameter int FF_IN   = 1,
  parameter int FF_MUL  = 1,
  parameter int FF_OUT  = 1,
  parameter int USE_CSA = 0,
  parameter int FF_CSA  = 0,
  parameter int FIFO_D  = 4
) (
  input  logic           clk,
  input  logic           rst,
  intmul_arbiter_if.slave bus
);
  localparam intmul_params_t MUL_P = '{ff_in: FF_IN, ff_mul: FF_MUL, ff_out: FF_OUT,
                                      use_csa: USE_CSA, ff_csa: FF_CSA};
  localparam int LAT   = intmul_lat(MUL_P);
  localparam int ID_W  = id_width(N_REQ);
  localparam int W_C   = W_A + W_B;
  localparam int CNT_W = $clog2(FIFO_D + 1);

  logic [ID_W-1:0]     ptr_r, gnt_id_s, tag_id_s;
  logic                gnt_found_s, can_issue_s, issue_s, pop_s, tag_vld_s;
  int                  idx_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s, fifo_count_s;
  logic                busy_r, fifo_empty_s, fifo_full_s, unused_fifo_s;
  logic [W_A-1:0]      mul_a_s;
  logic [W_B-1:0]      mul_b_s;
  logic [W_C-1:0]      mul_c_s;
  logic [ID_W+W_C-1:0] fifo_dout_s;

  // First valid requester at or after the round-robin pointer
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_id_s    = '0;
    idx_s       = 32'sd0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = (int'(ptr_r) + k >= N_REQ) ? int'(ptr_r) + k - N_REQ : int'(ptr_r) + k;
      if (!gnt_found_s && bus.req_valid[ID_W'(idx_s)]) begin
        gnt_found_s = 1'b1;
        gnt_id_s    = ID_W'(idx_s);
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Issue is gated on the registered credit count only, never on this cycle's pop.
  assign can_issue_s   = (cnt_r < CNT_W'(FIFO_D)) && !rst;
  assign issue_s       = gnt_found_s && can_issue_s;
  assign bus.req_ready = issue_s ? (N_REQ'(1'b1) << gnt_id_s) : '0;
  assign pop_s         = !fifo_empty_s && bus.rsp_ready;
  assign mul_a_s       = issue_s ? bus.req_a[int'(gnt_id_s)*W_A +: W_A] : '0;
  assign mul_b_s       = issue_s ? bus.req_b[int'(gnt_id_s)*W_B +: W_B] : '0;

  // Credits: everything issued and not yet popped
  always_comb begin
    case ({issue_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1'b1);
      2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1'b1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Round-robin pointer, credit counter and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      busy_r <= (cnt_nxt_s != '0);
      if (issue_s) begin
        ptr_r <= (gnt_id_s == ID_W'(N_REQ - 1)) ? '0 : gnt_id_s + ID_W'(1'b1);
      end
    end
  end

  intmul_standard #(
    .W_A(W_A), .W_B(W_B), .FF_IN(FF_IN), .FF_MUL(FF_MUL), .FF_OUT(FF_OUT),
    .USE_CSA(USE_CSA), .FF_CSA(FF_CSA)
  ) u_mul (
    .clk(clk), .a(mul_a_s), .b(mul_b_s), .c(mul_c_s)
  );

  if (LAT == 0) begin : g_tag_wire
    assign tag_vld_s = issue_s;
    assign tag_id_s  = gnt_id_s;
  end else begin : g_tag_pipe
    logic [LAT-1:0]  vld_r;
    logic [ID_W-1:0] id_r [LAT];
    // Tag valids; clearing them discards whatever the multiplier holds
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_r <= '0;
      end else begin
        vld_r[0] <= issue_s;
        for (int s = 1; s < LAT; s++) vld_r[s] <= vld_r[s-1];
      end
    end
    // Tag IDs travel alongside without reset
    always_ff @(posedge clk) begin
      id_r[0] <= gnt_id_s;
      for (int s = 1; s < LAT; s++) id_r[s] <= id_r[s-1];
    end
    assign tag_vld_s = vld_r[LAT-1];
    assign tag_id_s  = id_r[LAT-1];
  end

  intmul_arbiter_fifo #(.W(ID_W + W_C), .D(FIFO_D)) u_fifo (
    .clk(clk), .rst(rst), .push(tag_vld_s), .din({tag_id_s, mul_c_s}), .pop(pop_s),
    .dout(fifo_dout_s), .empty(fifo_empty_s), .full(fifo_full_s), .count(fifo_count_s)
  );

  assign unused_fifo_s = ^{fifo_full_s, fifo_count_s};
  assign bus.rsp_valid = !fifo_empty_s;
  assign bus.rsp_id    = fifo_dout_s[W_C +: ID_W];
  assign bus.rsp_c     = fifo_dout_s[W_C-1:0];
  assign bus.busy      = busy_r;
endmodule
